// File: rtl/radix4_mult_pkg.sv
// Shared constants and tag type for the radix-4 multiplier and its arbiter.
package radix4_mult_pkg;

    localparam int OP_W     = 32;
    localparam int RES_W    = 64;
    localparam int MAX_ID_W = 3;

    // Requester tag carried alongside each operation through the multiplier.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } mult_tag_t;

endpackage

// File: rtl/radix4_mult.sv
// Unsigned 32x32 multiplier using radix-4 Booth recoding, followed by LAT
// register stages. C is the product of A/B sampled LAT edges earlier.
module radix4_mult
    import radix4_mult_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic [RES_W-1:0] C
);

    // Operand zero-extended by two bits so the top digit is never negative.
    localparam int NDIG = (OP_W + 2) / 2;

    logic [OP_W+2:0]  bext;
    logic [2:0]       trip;
    logic [RES_W-1:0] mag;
    logic [RES_W-1:0] pp;
    logic [RES_W-1:0] prod;
    logic             neg;
    logic [RES_W-1:0] pipe [LAT];

    // Booth digits in {-2..+2}; partial products summed modulo 2^64, which is
    // exact because the true unsigned product always fits in 64 bits.
    always_comb begin
        bext = {2'b00, B, 1'b0};
        trip = '0;
        mag  = '0;
        pp   = '0;
        neg  = 1'b0;
        prod = '0;
        for (int unsigned j = 0; j < NDIG; j++) begin
            trip = bext[2*j +: 3];
            neg  = trip[2];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = RES_W'(A);
                3'b011, 3'b100:                 mag = RES_W'(A) << 1;
                default:                        mag = '0;
            endcase
            pp   = neg ? (~mag + 1'b1) : mag;
            prod = prod + (pp << (2 * j));
        end
    end

    // Product pipeline; stage 0 samples the freshly computed product.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= prod;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign C = pipe[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches from last_id+1 upward, wrapping, and
// remembers the last granted index so every requester gets its turn.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    logic [ID_W-1:0] last_id;
    int unsigned     idx;

    // First valid requester after the pointer, one-hot; nothing while disabled.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        if (en) begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
                idx = (int'(last_id) + off) % NREQ;
                if (!gnt_valid && req[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ID_W'(idx);
                    gnt[idx]  = 1'b1;
                end
            end
        end
    end

    // Pointer advances only when a grant actually transfers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= ID_W'(NREQ - 1);
        end else if (gnt_valid) begin
            last_id <= gnt_id;
        end
    end

endmodule

// File: rtl/radix4_mult_arbiter.sv
// Shares one radix4_mult among NREQ requesters: round-robin issue of one
// operand pair per cycle, with a tag pipeline that routes each product back
// to its owner on the shared response bus.
module radix4_mult_arbiter
    import radix4_mult_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 2,
    parameter int ID_W     = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    input  logic                 drain,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [RES_W-1:0]     rsp_c
);

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             arb_en;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] mult_c;
    mult_tag_t        tag_in;
    mult_tag_t        tag_q [MULT_LAT+1];
    mult_tag_t        tag_out;

    assign arb_en    = ~drain;
    assign req_ready = gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req       (req_valid),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Granted operands are captured; idle cycles feed zeros to the multiplier.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
        end else if (gnt_valid) begin
            op_a <= req_a[int'(gnt_id)*OP_W +: OP_W];
            op_b <= req_b[int'(gnt_id)*OP_W +: OP_W];
        end else begin
            op_a <= '0;
            op_b <= '0;
        end
    end

    radix4_mult #(
        .LAT (MULT_LAT)
    ) u_mult (
        .CLK   (CLK),
        .rst_n (rst_n),
        .A     (op_a),
        .B     (op_b),
        .C     (mult_c)
    );

    // Tag entering stage 0 mirrors the grant made this cycle.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = gnt_valid;
        tag_in.id    = MAX_ID_W'(gnt_id);
    end

    // Tag shift register, one stage per operand/multiplier register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= MULT_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i <= MULT_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[MULT_LAT];

    // Response register; id and product hold between pulses.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
        end else begin
            rsp_valid <= tag_out.valid;
            if (tag_out.valid) begin
                rsp_id <= tag_out.id[ID_W-1:0];
                rsp_c  <= mult_c;
            end
        end
    end

    // Busy while any tag is in flight or a response is being presented.
    always_comb begin
        busy = rsp_valid;
        for (int unsigned i = 0; i <= MULT_LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

endmodule
